// File: rtl/ipml_fifo_rd_pkg.sv
// Shared constants for the FIFO read-side streaming adapter.
// Macro IPML_FIFO_RD_OREG_EN selects the two-cycle read latency of a FIFO built with its output register.
package ipml_fifo_rd_pkg;

`ifdef IPML_FIFO_RD_OREG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Depth must cover every read in flight plus room for one beat being consumed.
  function automatic bit depth_legal(input int depth);
    return ((depth == 4) || (depth == 8)) && (depth >= RD_LATENCY + 2);
  endfunction

endpackage

// File: rtl/ipml_fifo_rd_skid.sv
// Circular skid buffer: storage, read/write pointers and occupancy for the read-side stream.
module ipml_fifo_rd_skid
  import ipml_fifo_rd_pkg::*;
#(
  parameter int c_DATA_WIDTH = 16,
  parameter int c_BUF_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                capture,
  input  logic [c_DATA_WIDTH-1:0]             capture_data,
  input  logic                                ready,
  output logic                                valid,
  output logic [c_DATA_WIDTH-1:0]             data,
  output logic [level_width(c_BUF_DEPTH)-1:0] level
);

  localparam int PW = $clog2(c_BUF_DEPTH);
  localparam int LW = level_width(c_BUF_DEPTH);

  logic [c_DATA_WIDTH-1:0] mem [c_BUF_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(c_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid = (level != '0);
  assign pop   = valid && ready;
  assign data  = mem[rd_ptr];

  // Storage is data only: stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= capture_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (capture) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      case ({capture, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (level == LW'(c_BUF_DEPTH))));

endmodule

// File: rtl/ipml_fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter with credit-based read issue and a skid buffer.
// Read latency follows macro IPML_FIFO_RD_OREG_EN (see ipml_fifo_rd_pkg).
module ipml_fifo_rd_stream
  import ipml_fifo_rd_pkg::*;
#(
  parameter int c_DATA_WIDTH = 16,
  parameter int c_BUF_DEPTH  = 4
) (
  input  logic                          rd_clk,
  input  logic                          rd_rst_n,
  output logic                          fifo_rd_en,
  input  logic                          fifo_rd_empty,
  input  logic [c_DATA_WIDTH-1:0]       fifo_rd_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [c_DATA_WIDTH-1:0]       m_data,
  output logic [$clog2(c_BUF_DEPTH):0]  buf_level
);

  localparam int L  = RD_LATENCY;
  localparam int LW = level_width(c_BUF_DEPTH);

  generate
    if (!depth_legal(c_BUF_DEPTH)) begin : g_bad_depth
      $error("c_BUF_DEPTH must be 4 or 8 and at least read latency + 2");
    end
    if ((c_DATA_WIDTH < 1) || (c_DATA_WIDTH > 1152)) begin : g_bad_width
      $error("c_DATA_WIDTH must be in 1..1152");
    end
  endgenerate

  logic [L-1:0]  rd_pipe;
  logic [LW-1:0] inflight;
  logic [LW:0]   committed;
  logic          capture;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + LW'(rd_pipe[i]);
  end

  // Credit counts buffered plus in-flight words; a pop this cycle is deliberately not credited.
  assign committed  = {1'b0, buf_level} + {1'b0, inflight};
  assign fifo_rd_en = rd_rst_n && !fifo_rd_empty && (committed < (LW+1)'(c_BUF_DEPTH));
  assign capture    = rd_pipe[L-1];

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) rd_pipe <= '0;
    else           rd_pipe <= L'({rd_pipe, fifo_rd_en});
  end

  ipml_fifo_rd_skid #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_BUF_DEPTH  (c_BUF_DEPTH)
  ) u_skid (
    .clk          (rd_clk),
    .rst_n        (rd_rst_n),
    .capture      (capture),
    .capture_data (fifo_rd_data),
    .ready        (m_ready),
    .valid        (m_valid),
    .data         (m_data),
    .level        (buf_level)
  );

endmodule

// File: tb/tb_ipml_fifo_rd_stream.sv
// Bench for ipml_fifo_rd_stream: two instances (depth 4 and 8) against a cycle-level reference model.
module tb_ipml_fifo_rd_stream;

`ifdef IPML_FIFO_RD_OREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ready;
  logic [15:0] src [4096];
  int wr_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [1:0]       en, empty, valid;
  logic [1:0][15:0] data;
  logic [1:0][3:0]  level;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    src[wr_cnt] = w;
    wr_cnt++;
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D   = (g == 0) ? 4 : 8;
    localparam int LWD = $clog2(D) + 1;
    logic [LWD-1:0] lvl;
    logic [15:0] st1, st2, fd;
    int rd_ptr = 0;

    assign fd       = (L == 2) ? st2 : st1;
    assign level[g] = 4'(lvl);
    assign empty[g] = (rd_ptr == wr_cnt);

    ipml_fifo_rd_stream #(.c_DATA_WIDTH(16), .c_BUF_DEPTH(D)) dut (
      .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(en[g]), .fifo_rd_empty(empty[g]),
      .fifo_rd_data(fd), .m_valid(valid[g]), .m_ready(ready), .m_data(data[g]), .buf_level(lvl));

    // FIFO read port: data is meaningful only in the capture cycle, garbage otherwise.
    always @(posedge clk) begin
      st2 <= st1;
      if (en[g] && !empty[g]) begin
        st1 <= src[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end else begin
        st1 <= 16'($urandom);
      end
    end

    // Reference: every read issued in cycle t is poppable from cycle t+L+1; credit = issued - popped.
    int issued = 0, popped = 0, arrived = 0, mbase = 0, cyc = 0, e_level = 0;
    int iss_cyc [4096];
    bit armed = 0, e_en = 0, e_valid = 0, e_pop = 0;
    initial begin
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          mbase = mbase + issued;
          issued = 0; popped = 0; arrived = 0; armed = 1;
        end else if (armed) begin
          if (e_en) begin iss_cyc[issued] = cyc; issued++; end
          if (e_pop) popped++;
        end
        cyc++;
        @(negedge clk);
        if (armed) begin
          while (arrived < issued && iss_cyc[arrived] + L + 1 <= cyc) arrived++;
          e_level = arrived - popped;
          e_valid = (e_level != 0);
          e_en    = rst_n && (mbase + issued != wr_cnt) && (issued - popped < D);
          e_pop   = e_valid && ready;
          chk($sformatf("dut%0d_rd_en", g), en[g], e_en);
          chk($sformatf("dut%0d_m_valid", g), valid[g], e_valid);
          chk($sformatf("dut%0d_buf_level", g), level[g], e_level);
          if (e_valid) chk($sformatf("dut%0d_m_data", g), data[g], src[mbase + popped]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int fe [2], fv [2], lv [2], nb [2], nr [2], bad [2], pops [2], exp0 [2];
  int np;
  bit found;

  initial begin
    rst_n = 1'b0;
    ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(16'(i));

    // Reset held with a non-empty FIFO
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_rd_en", en[d], 0);
        chk("rst_m_valid", valid[d], 0);
        chk("rst_buf_level", level[d], 0);
      end
    end

    // Streaming 0x0001..0x0010 with ready high
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin fe[d] = -1; fv[d] = -1; lv[d] = -1; nb[d] = 0; end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (en[d] && fe[d] < 0) fe[d] = c;
        if (valid[d]) begin
          if (fv[d] < 0) fv[d] = c;
          chk("stream_data", data[d], nb[d] + 1);
          nb[d]++;
          lv[d] = c;
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      chk("stream_first_rd_en", fe[d], 0);
      chk("stream_latency", fv[d] - fe[d], L + 1);
      chk("stream_beats", nb[d], 16);
      chk("stream_back_to_back", lv[d] - fv[d], 15);
    end

    // Backpressure with 10 words available
    ready = 1'b0;
    for (int i = 0; i < 10; i++) push(16'(16'h0200 + i));
    for (int d = 0; d < 2; d++) nr[d] = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (en[d]) nr[d]++;
        if (valid[d]) chk("bp_data_hold", data[d], 16'h0200);
        if (c == 13) begin
          chk("bp_level_full", level[d], depth_of(d));
          chk("bp_valid_held", valid[d], 1);
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) chk("bp_reads_issued", nr[d], depth_of(d));
    ready = 1'b1;
    for (int d = 0; d < 2; d++) nb[d] = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (valid[d]) begin chk("bp_release_data", data[d], 16'h0200 + nb[d]); nb[d]++; end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) chk("bp_release_beats", nb[d], 10);

    // FIFO runs empty after three words
    for (int i = 0; i < 3; i++) push(16'(16'h0300 + i));
    for (int d = 0; d < 2; d++) begin nr[d] = 0; bad[d] = 0; nb[d] = 0; end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (en[d]) nr[d]++;
        if (en[d] && empty[d]) bad[d]++;
        if (valid[d]) begin chk("empty_data", data[d], 16'h0300 + nb[d]); nb[d]++; end
        if (c == 11) chk("empty_valid_low", valid[d], 0);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      chk("empty_reads", nr[d], 3);
      chk("empty_read_while_empty", bad[d], 0);
      chk("empty_beats", nb[d], 3);
    end

    // Mid-stream reset while the depth-8 buffer holds 3 words and L reads are in flight
    ready = 1'b0;
    for (int i = 0; i < 20; i++) push(16'(16'h0400 + i));
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (level[1] == 4'd3) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("mid_reach_level3", found, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_level", level[d], 0);
      chk("mid_rst_valid", valid[d], 0);
    end
    @(posedge clk); #1;
    exp0[0] = 4;
    exp0[1] = 3 + L;
    for (int d = 0; d < 2; d++) nb[d] = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (valid[d]) begin chk("mid_after_data", data[d], 16'h0400 + exp0[d] + nb[d]); nb[d]++; end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) chk("mid_after_beats", nb[d], 20 - exp0[d]);

    // 1000 random words with random ready
    np = 0;
    for (int d = 0; d < 2; d++) pops[d] = 0;
    for (int c = 0; c < 8000 && !(pops[0] == 1000 && pops[1] == 1000); c++) begin
      ready = 1'($urandom_range(0, 1));
      if (np < 1000 && $urandom_range(0, 3) != 0) begin
        push(16'($urandom));
        np++;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (valid[d] && ready) pops[d]++;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) chk("random_beats", pops[d], 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
